fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Round-robin scheduler that shares one combinational `fp_adder` (IEEE-754 single precision, `s = a + b`) among `N_REQ` requesters. Each requester uses a valid/ready request handshake. The block registers the winning operands, lets the adder settle for one cycle, and returns the registered sum on a single valid/ready response channel tagged with the requester index. It sits between the compute clients and the shared adder datapath.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_a`, in, N_REQ*32: operand a; requester i occupies bits [32i+31:32i].
- `req_b`, in, N_REQ*32: operand b, same packing as `req_a`.
- `req_ready`, out, N_REQ: one-hot grant/accept, or all zero.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_id`, out, ID_W: index of the requester that owns the result.
- `rsp_s`, out, 32: registered sum.
- `busy`, out, 1: high when state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is set, grant index g, the first valid index searching from `ptr+1` modulo N_REQ upward.
  - `req_ready[g]` = 1 combinationally in this cycle. The handshake completes this cycle.
  - At the clock edge: latch `req_a[g]`, `req_b[g]` and g; set `ptr` = g; go to EXEC.
  - If no request is valid: stay in IDLE; `ptr` does not change.
- EXEC:
  - Latched operands drive `fp_adder`.
  - At the clock edge: `rsp_s` ← adder `s`, `rsp_id` ← latched g; go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_s` and `rsp_id` are held stable until `rsp_valid & rsp_ready`. On that handshake, go to IDLE.
- `req_ready` is all zero outside IDLE. Requests are never accepted while an operation is in flight.
- `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Requesters hold `req_valid`, `req_a` and `req_b` stable until accepted.
- No arithmetic is done in this block. IEEE behaviour (rounding, specials) belongs entirely to `fp_adder`. Results pass through bit-exact.
- Reset values: state IDLE; `ptr` = N_REQ-1, so requester 0 has first priority; `req_ready` = 0; `rsp_valid` = 0; `rsp_id` = 0; `rsp_s` = 0; `busy` = 0; operand registers = 0.
- Reset mid-operation: if `rst_n` is sampled low in EXEC or RESP, the in-flight result is discarded and the requester receives no response. All outputs are at reset values in the cycle after the sampling edge.

## Timing
- Request accepted in cycle T (`req_valid[g] & req_ready[g]`): `rsp_valid` rises in cycle T+2.
- `rsp_ready` high in T+2: next acceptance is at earliest T+3.
- Peak throughput: 1 operation per 3 cycles.
- `rsp_ready` low: RESP holds indefinitely, `busy` = 1, no grants.
- Combinational path: the full `fp_adder` delay spans exactly one register-to-register cycle (operand registers → `rsp_s`).
- `busy` is registered: it equals (state != IDLE).

## Structure
- Package `fp_add_pkg`: `FP_W` = 32; state enum {IDLE, EXEC, RESP}.
- Sub-module `rr_arbiter`:
  - Inputs: `req`[N_REQ], `ptr`.
  - Outputs: `gnt` (one-hot), `gnt_idx`, `any`.
  - Purely combinational, reusable.
- Existing `fp_adder` is instantiated unchanged (ports `a`, `b`, `s`).

## Test plan
- **Single request:** requester 0, a=3f800000, b=40000000, accepted cycle T → `rsp_valid` at T+2, `rsp_id`=0, `rsp_s`=40400000.
- **All requesters valid after reset:** operands 40400000+bf800000 on each, `rsp_ready`=1 → grants 0,1,2,3 in that order, 3 cycles apart; every `rsp_s`=40000000.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP with c0a00000+40a00000 → `rsp_valid`, `rsp_id` and `rsp_s`=00000000 stable; `req_ready`=0; `busy`=1. Release → IDLE next cycle.
- **Fairness:** requesters 0 and 2 continuously valid → grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
- **Reset mid-operation:** `rst_n` low during EXEC → next cycle `rsp_valid`=0, `busy`=0, `rsp_s`=0. With 0 and 3 then valid, requester 0 is granted first.
- **Regression vectors:** replay the team's 28-entry fp.hex vector set through requester 3 → every `rsp_s` bit-exact to the expected value, `rsp_id`=3.

Source files
------------

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared width and FSM state type
// for the shared fp adder arbiter.
package fp_add_pkg;
    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/fp_adder.sv
// fp_adder: combinational IEEE-754 single add,
// round to nearest even, canonical quiet NaN.
module fp_adder
    import fp_add_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] s
);
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap, sl, same, st, g, rb;
    logic [31:0] lg;
    logic [30:0] sm;
    logic [7:0]  el, es, d;
    logic [23:0] ml, ms, mant;
    logic [26:0] ext, sh, ms_x;
    logic [27:0] r;
    logic [9:0]  e, lz, shamt;
    logic [24:0] m25;

    always_comb begin
        a_nan = (&a[30:23]) & (|a[22:0]);
        b_nan = (&b[30:0+23]) & (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);
        swap  = b[30:0] > a[30:0];
        lg    = swap ? b : a;
        sm    = swap ? a[30:0] : b[30:0];
        sl    = lg[31];
        same  = a[31] == b[31];
        el    = (lg[30:23] == 8'd0) ? 8'd1 : lg[30:23];
        es    = (sm[30:23] == 8'd0) ? 8'd1 : sm[30:23];
        ml    = {|lg[30:23], lg[22:0]};
        ms    = {|sm[30:23], sm[22:0]};
        d     = el - es;
        ext   = {ms, 3'b000};
        if (d > 8'd26) begin
            sh = '0;
            st = |ms;
        end else begin
            sh = ext >> d;
            st = |(ext & ~({27{1'b1}} << d));
        end
        ms_x = {sh[26:1], sh[0] | st};
        r = same ? {1'b0, ml, 3'b000} + {1'b0, ms_x}
                 : {1'b0, ml, 3'b000} - {1'b0, ms_x};
        e     = {2'b00, el};
        lz    = 10'd27;
        shamt = '0;
        // Left shift stops at exponent 1 to form subnormals.
        if (r[27]) begin
            r = {1'b0, r[27:2], r[1] | r[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (r[i]) lz = 10'(26 - i);
            shamt = (lz > e - 10'd1) ? e - 10'd1 : lz;
            r     = r << shamt;
            e     = e - shamt;
        end
        mant = r[26:3];
        g    = r[2];
        rb   = r[1] | r[0];
        m25  = {1'b0, mant} + {24'd0, g & (rb | mant[0])};
        if (m25[24]) begin
            m25 = m25 >> 1;
            e   = e + 10'd1;
        end
        if (a_nan | b_nan | (a_inf & b_inf & ~same))
            s = 32'h7fc00000;
        else if (a_inf)
            s = a;
        else if (b_inf)
            s = b;
        else if (r == '0)
            s = {a[31] & b[31], 31'd0};
        else if (e >= 10'd255)
            s = {sl, 8'hff, 23'd0};
        else
            s = {sl, m25[23] ? e[7:0] : 8'h00, m25[22:0]};
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// searching upward from ptr+1.
module rr_arbiter
    import fp_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);
    int idx;

    // Walk far-to-near so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                any     = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        gnt = '0;
        if (any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one fp_adder
// among N_REQ requesters, one op per three cycles.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_s,
    output logic               busy
);
    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  op_id;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             any;
    logic [FP_W-1:0]  op_a;
    logic [FP_W-1:0]  op_b;
    logic [FP_W-1:0]  sum;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .any    (any)
    );

    fp_adder u_add (
        .a(op_a),
        .b(op_b),
        .s(sum)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= ID_W'(N_REQ - 1);
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
            rsp_s  <= '0;
            rsp_id <= '0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (any) begin
                    op_a  <= req_a[FP_W*gnt_idx +: FP_W];
                    op_b  <= req_b[FP_W*gnt_idx +: FP_W];
                    op_id <= gnt_idx;
                    ptr   <= gnt_idx;
                    state <= EXEC;
                    busy  <= 1'b1;
                end
                EXEC: begin
                    rsp_s  <= sum;
                    rsp_id <= op_id;
                    state  <= RESP;
                end
                RESP: if (rsp_ready) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: vector table, directed corner
// sequences and a randomized scoreboard run.
module tb_fp_add_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_s;
    logic          busy;

    fp_add_arbiter #(.N_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_s    (rsp_s),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] s;
        int          acc;
    } op_t;

    int checks = 0;
    int errors = 0;

    vec_t vt[28];
    op_t  q[$];
    int   glog[$];
    logic pend[N];
    int   ia[N];
    int   ib[N];
    int   lastg;
    int   ecyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact encoding of a small integer as a single-precision float.
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m;
        logic        sgn;
        int          p;
        if (v == 0) return 32'd0;
        sgn = (v < 0);
        m   = sgn ? 32'(-v) : 32'(v);
        p   = 0;
        for (int i = 0; i < 31; i++)
            if (m[i]) p = i;
        return {sgn, 8'(127 + p), 23'(m << (23 - p))};
    endfunction

    function automatic int rnd_op();
        return int'($urandom_range(0, 2097152)) - 1048576;
    endfunction

    task automatic set_req(input int i, input logic v,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = v;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic model_reset();
        q.delete();
        glog.delete();
        lastg = N - 1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_op(input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] s,
                         input string name);
        @(negedge clk);
        set_req(id, 1'b1, a, b);
        #1;
        chk({name, " grant"}, 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({name, " exec valid"}, 32'(rsp_valid), 32'd0);
        chk({name, " exec busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rsp_id"}, 32'(rsp_id), 32'(id));
        chk({name, " rsp_s"}, rsp_s, s);
    endtask

    task automatic run_engine(input int ncyc, input logic [N-1:0] mask,
                              input bit rand_valid, input bit rand_ready,
                              input bit allow_new);
        bit          idle;
        bit          exp_rv;
        int          g;
        int          j;
        logic [31:0] exp_rr;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (allow_new && mask[i] && !pend[i] &&
                    (!rand_valid || $urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    ia[i]   = rnd_op();
                    ib[i]   = rnd_op();
                end
                set_req(i, pend[i], i2f(ia[i]), i2f(ib[i]));
            end
            rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            idle   = (q.size() == 0);
            exp_rv = !idle && (ecyc >= q[0].acc + 2);
            chk("rr rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv && rsp_valid) begin
                chk("rr rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rr rsp_s", rsp_s, q[0].s);
                if (rsp_ready) void'(q.pop_front());
            end
            g = -1;
            if (idle)
                for (int k = 1; k <= N; k++) begin
                    j = (lastg + k) % N;
                    if (pend[j] && g < 0) g = j;
                end
            exp_rr = (g >= 0) ? (32'(1) << g) : 32'd0;
            chk("rr grant", 32'(req_ready), exp_rr);
            if (g >= 0) begin
                q.push_back('{g, i2f(ia[g] + ib[g]), ecyc});
                pend[g] = 1'b0;
                lastg   = g;
                glog.push_back(g);
            end
            ecyc++;
        end
    endtask

    initial begin
        int gl_id[$];
        int gl_cy[$];
        int idx;

        vt[0]  = '{32'h3f800000, 32'h40000000, 32'h40400000};
        vt[1]  = '{32'h40400000, 32'hbf800000, 32'h40000000};
        vt[2]  = '{32'hc0a00000, 32'h40a00000, 32'h00000000};
        vt[3]  = '{32'h00000000, 32'h00000000, 32'h00000000};
        vt[4]  = '{32'h80000000, 32'h80000000, 32'h80000000};
        vt[5]  = '{32'h00000000, 32'h80000000, 32'h00000000};
        vt[6]  = '{32'h3f800000, 32'hbf800000, 32'h00000000};
        vt[7]  = '{32'h7f800000, 32'h3f800000, 32'h7f800000};
        vt[8]  = '{32'hff800000, 32'h3f800000, 32'hff800000};
        vt[9]  = '{32'h7f800000, 32'hff800000, 32'h7fc00000};
        vt[10] = '{32'h7fc00000, 32'h3f800000, 32'h7fc00000};
        vt[11] = '{32'h7f800000, 32'h7f800000, 32'h7f800000};
        vt[12] = '{32'h7f7fffff, 32'h7f7fffff, 32'h7f800000};
        vt[13] = '{32'h3f800000, 32'h33800000, 32'h3f800000};
        vt[14] = '{32'h3f800001, 32'h33800000, 32'h3f800002};
        vt[15] = '{32'h3f800000, 32'h33800001, 32'h3f800001};
        vt[16] = '{32'h3f800000, 32'hb3800000, 32'h3f7fffff};
        vt[17] = '{32'h00000001, 32'h00000001, 32'h00000002};
        vt[18] = '{32'h00400000, 32'h00400000, 32'h00800000};
        vt[19] = '{32'h00800000, 32'h80000001, 32'h007fffff};
        vt[20] = '{32'h3fc00000, 32'h3fc00000, 32'h40400000};
        vt[21] = '{32'h41200000, 32'hc1a00000, 32'hc1200000};
        vt[22] = '{32'h4b800000, 32'h3f800000, 32'h4b800000};
        vt[23] = '{32'h4b800000, 32'h40000000, 32'h4b800001};
        vt[24] = '{32'h4b800000, 32'h40400000, 32'h4b800002};
        vt[25] = '{32'h3f800000, 32'h00000001, 32'h3f800000};
        vt[26] = '{32'h42c80000, 32'hc2c60000, 32'h3f800000};
        vt[27] = '{32'hffc00000, 32'h00000000, 32'h7fc00000};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        ecyc      = 0;
        model_reset();

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_s", rsp_s, 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        reset_dut();

        do_op(0, 32'h3f800000, 32'h40000000, 32'h40400000, "single");

        // All requesters valid straight after reset.
        reset_dut();
        @(negedge clk);
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 32'h40400000, 32'hbf800000);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++)
                    if (req_ready[i]) idx = i;
                gl_id.push_back(idx);
                gl_cy.push_back(c);
            end
            if (rsp_valid) chk("all rsp_s", rsp_s, 32'h40000000);
            @(negedge clk);
        end
        req_valid = '0;
        chk("all grant count", 32'(gl_id.size()), 32'd4);
        for (int k = 0; k < gl_id.size(); k++) begin
            chk("all grant id", 32'(gl_id[k]), 32'(k));
            chk("all grant cycle", 32'(gl_cy[k]), 32'(3 * k));
        end
        repeat (3) @(negedge clk);

        // Backpressure holds RESP and blocks other grants.
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'hc0a00000, 32'h40a00000);
        #1;
        chk("bp grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0);
        set_req(2, 1'b1, 32'h3f800000, 32'h3f800000);
        #1;
        chk("bp exec req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_id", 32'(rsp_id), 32'd1);
            chk("bp rsp_s", rsp_s, 32'h00000000);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp release valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("bp idle busy", 32'(busy), 32'd0);
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 28; v++)
            do_op(3, vt[v].a, vt[v].b, vt[v].s, $sformatf("vec%0d", v));

        // Reset sampled during EXEC discards the operation.
        @(negedge clk);
        set_req(0, 1'b1, 32'h3f800000, 32'h40000000);
        #1;
        chk("midrst grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("midrst exec busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h3f800000, 32'h3f800000);
        set_req(3, 1'b1, 32'h3f800000, 32'h3f800000);
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rsp_s", rsp_s, 32'd0);
        chk("midrst rsp_id", 32'(rsp_id), 32'd0);
        chk("midrst grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Fairness between requesters 0 and 2.
        reset_dut();
        run_engine(24, 4'b0101, 1'b0, 1'b0, 1'b1);
        chk("fair count", 32'(glog.size()), 32'd8);
        for (int k = 0; k < glog.size(); k++)
            chk("fair order", 32'(glog[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        run_engine(12, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("fair drain", 32'(q.size()), 32'd0);

        // Randomized traffic with random backpressure.
        run_engine(300, 4'b1111, 1'b1, 1'b1, 1'b1);
        run_engine(40, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rand drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
